// File: rtl/ss_pkg.sv
// Shared types and constants for the seven-segment scan/PWM display driver.
// All segment and driver codes are active-low.
package ss_pkg;

    typedef enum logic {
        S_BLANK = 1'b0,
        S_ON    = 1'b1
    } scan_state_e;

    // Segment order is {DP,G,F,E,D,C,B,A}; DP bit left high (off) in every digit code.
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] DRV_OFF   = 8'hFF;

    localparam logic [1:0] DIGIT_COLON = 2'd2;
    localparam logic [1:0] DIGIT_LAST  = 2'd3;

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to active-low seven-segment decoder (segments G..A).
// Non-decimal codes 10..15 produce a blank digit.
module bcd_to_7seg
    import ss_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg_n
);

    always_comb begin
        seg_n = SEG_BLANK[6:0];
        case (bcd)
            4'd0:    seg_n = SEG_0[6:0];
            4'd1:    seg_n = SEG_1[6:0];
            4'd2:    seg_n = SEG_2[6:0];
            4'd3:    seg_n = SEG_3[6:0];
            4'd4:    seg_n = SEG_4[6:0];
            4'd5:    seg_n = SEG_5[6:0];
            4'd6:    seg_n = SEG_6[6:0];
            4'd7:    seg_n = SEG_7[6:0];
            4'd8:    seg_n = SEG_8[6:0];
            4'd9:    seg_n = SEG_9[6:0];
            default: seg_n = SEG_BLANK[6:0];
        endcase
    end

endmodule

// File: rtl/ss_scan_pwm_driver.sv
// Multiplexes HH:MM onto digits 3..0 of a common-anode display with a blanking gap
// at the start of each slot, PWM dimming, leading-zero blanking and a colon DP.
module ss_scan_pwm_driver
    import ss_pkg::*;
#(
    parameter int CLK_HZ       = 100_000_000,
    parameter int DIGIT_HZ     = 1000,
    parameter int BLANK_CYCLES = 100
) (
    input  logic       CLK100MHZ,
    input  logic       RESET_N,
    input  logic [3:0] hours2,
    input  logic [3:0] hours1,
    input  logic [3:0] mins2,
    input  logic [3:0] mins1,
    input  logic [7:0] pwm_in,
    input  logic       colon_in,
    input  logic       lzb_en,
    output logic [7:0] SegmentDrivers,
    output logic [7:0] SevenSegment,
    output logic       frame_done
);

    localparam int P  = CLK_HZ / DIGIT_HZ;
    localparam int SW = (P > 2) ? $clog2(P) : 1;

    localparam logic [SW-1:0] SLOT_LAST  = SW'(P - 1);
    localparam logic [SW-1:0] SLOT_BLANK = SW'(BLANK_CYCLES);

    logic [SW-1:0] slot_cnt_q, slot_cnt_d;
    logic [1:0]    digit_q, digit_d;
    scan_state_e   state_q, state_d;
    logic [7:0]    pwm_cnt_q, pwm_cnt_d;
    logic [7:0]    duty_q, duty_d;
    logic [3:0]    opr_val_q, opr_val_d;
    logic          opr_colon_q, opr_colon_d;
    logic          opr_lzb_q, opr_lzb_d;
    logic [7:0]    drv_q, drv_d;
    logic [7:0]    seg_q, seg_d;
    logic          frame_done_q, frame_done_d;

    logic          slot_wrap;
    logic [3:0]    digit_sel;
    logic [6:0]    dec_seg_n;
    logic          lz_blank;
    logic          dp_n;

    bcd_to_7seg u_dec (
        .bcd   (opr_val_q),
        .seg_n (dec_seg_n)
    );

    always_comb begin
        digit_sel = mins1;
        case (digit_q)
            2'd0:    digit_sel = mins1;
            2'd1:    digit_sel = mins2;
            2'd2:    digit_sel = hours1;
            default: digit_sel = hours2;
        endcase
    end

    always_comb begin
        slot_wrap = (slot_cnt_q == SLOT_LAST);

        slot_cnt_d = slot_wrap ? '0 : slot_cnt_q + SW'(1);
        digit_d    = slot_wrap ? digit_q + 2'd1 : digit_q;
        // State tracks the counter value it is registered alongside.
        state_d    = (slot_cnt_d < SLOT_BLANK) ? S_BLANK : S_ON;

        pwm_cnt_d = pwm_cnt_q + 8'd1;
        duty_d    = (pwm_cnt_q == 8'hFF) ? pwm_in : duty_q;

        // Operands are frozen for the whole slot so mid-slot input changes cannot glitch.
        opr_val_d   = opr_val_q;
        opr_colon_d = opr_colon_q;
        opr_lzb_d   = opr_lzb_q;
        if (slot_cnt_q == '0) begin
            opr_val_d   = digit_sel;
            opr_colon_d = colon_in;
            opr_lzb_d   = lzb_en;
        end

        lz_blank = (digit_q == DIGIT_LAST) && opr_lzb_q && (opr_val_q == 4'd0);
        dp_n     = !((digit_q == DIGIT_COLON) && opr_colon_q);

        seg_d = SEG_BLANK;
        drv_d = DRV_OFF;
        if (state_q == S_ON && !lz_blank) begin
            seg_d = {dp_n, dec_seg_n};
            if (pwm_cnt_q < duty_q) begin
                drv_d = ~(8'b0000_0001 << digit_q);
            end
        end

        frame_done_d = slot_wrap && (digit_q == DIGIT_LAST);
    end

    always_ff @(posedge CLK100MHZ or negedge RESET_N) begin
        if (!RESET_N) begin
            slot_cnt_q   <= '0;
            digit_q      <= 2'd0;
            state_q      <= S_BLANK;
            pwm_cnt_q    <= 8'd0;
            duty_q       <= 8'd0;
            opr_val_q    <= 4'd0;
            opr_colon_q  <= 1'b0;
            opr_lzb_q    <= 1'b0;
            drv_q        <= DRV_OFF;
            seg_q        <= SEG_BLANK;
            frame_done_q <= 1'b0;
        end else begin
            slot_cnt_q   <= slot_cnt_d;
            digit_q      <= digit_d;
            state_q      <= state_d;
            pwm_cnt_q    <= pwm_cnt_d;
            duty_q       <= duty_d;
            opr_val_q    <= opr_val_d;
            opr_colon_q  <= opr_colon_d;
            opr_lzb_q    <= opr_lzb_d;
            drv_q        <= drv_d;
            seg_q        <= seg_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign SegmentDrivers = drv_q;
    assign SevenSegment   = seg_q;
    assign frame_done     = frame_done_q;

endmodule

// File: tb/tb_ss_scan_pwm_driver.sv
// Directed bench for the scan/PWM display driver with P=10 and a 2-cycle blanking gap.
// Expected pin values are derived from the edge count since reset release.
module tb_ss_scan_pwm_driver;

    logic       clk = 1'b0;
    logic       RESET_N;
    logic [3:0] hours2, hours1, mins2, mins1;
    logic [7:0] pwm_in;
    logic       colon_in, lzb_en;
    logic [7:0] SegmentDrivers, SevenSegment;
    logic       frame_done;

    int checks   = 0;
    int failures = 0;
    int cyc;

    ss_scan_pwm_driver #(
        .CLK_HZ       (1000),
        .DIGIT_HZ     (100),
        .BLANK_CYCLES (2)
    ) dut (
        .CLK100MHZ      (clk),
        .RESET_N        (RESET_N),
        .hours2         (hours2),
        .hours1         (hours1),
        .mins2          (mins2),
        .mins1          (mins1),
        .pwm_in         (pwm_in),
        .colon_in       (colon_in),
        .lzb_en         (lzb_en),
        .SegmentDrivers (SegmentDrivers),
        .SevenSegment   (SevenSegment),
        .frame_done     (frame_done)
    );

    always #5 clk = ~clk;

    // Edges since reset release == the DUT's internal counter value after that edge.
    always @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        checks++;
        if ($countones(~SegmentDrivers) > 1 || SegmentDrivers[7:4] !== 4'hF) begin
            failures++;
            $display("FAIL onehot_enable cyc=%0d got=%h required at most one of bits 3..0 low", cyc, SegmentDrivers);
        end
    end

    // Pins seen after edge c reflect counter state c-1.
    function automatic logic [7:0] drv_exp(input int c, input int duty, input bit blank3);
        int m, slot, dig, pw;
        logic [7:0] one;
        m = c - 1; slot = m % 10; dig = (m / 10) % 4; pw = m % 256; one = 8'h01;
        if (m < 0 || slot < 2 || pw >= duty || (blank3 && dig == 3)) return 8'hFF;
        return ~(one << dig);
    endfunction

    function automatic logic [7:0] seg_exp(input int c, input logic [7:0] t0, input logic [7:0] t1,
                                           input logic [7:0] t2, input logic [7:0] t3);
        int m, dig;
        m = c - 1; dig = (m / 10) % 4;
        if (m < 0 || m % 10 < 2) return 8'hFF;
        case (dig)
            0:       return t0;
            1:       return t1;
            2:       return t2;
            default: return t3;
        endcase
    endfunction

    function automatic logic fd_exp(input int c);
        int m;
        m = c - 1;
        return (m >= 0) && (m % 10 == 9) && ((m / 10) % 4 == 3);
    endfunction

    // Wait until a duty latch taking the current pwm_in governs the pins.
    task automatic wait_duty();
        int n;
        @(negedge clk);
        @(negedge clk);
        n = 0;
        while (cyc % 256 != 1 && n < 600) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 600) begin
            failures++;
            $display("FAIL wait_duty_timeout cyc=%0d required cyc%%256==1", cyc);
        end
    endtask

    task automatic run_slots(input string name, input int n, input int duty, input bit blank3,
                             input logic [7:0] t0, input logic [7:0] t1,
                             input logic [7:0] t2, input logic [7:0] t3);
        logic [7:0] ed, es;
        logic ef;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ed = drv_exp(cyc, duty, blank3);
            es = seg_exp(cyc, t0, t1, t2, t3);
            ef = fd_exp(cyc);
            checks += 3;
            if (SegmentDrivers !== ed) begin
                failures++;
                $display("FAIL %s_drv cyc=%0d got=%h exp=%h", name, cyc, SegmentDrivers, ed);
            end
            if (SevenSegment !== es) begin
                failures++;
                $display("FAIL %s_seg cyc=%0d got=%h exp=%h", name, cyc, SevenSegment, es);
            end
            if (frame_done !== ef) begin
                failures++;
                $display("FAIL %s_frame_done cyc=%0d got=%b exp=%b", name, cyc, frame_done, ef);
            end
        end
        $display("txn %s: %0d cycles checked, duty=%0d", name, n, duty);
    endtask

    task automatic check_restart(input string name);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            checks += 2;
            if (SegmentDrivers !== 8'hFF) begin
                failures++;
                $display("FAIL %s_drv_dark cyc=%0d got=%h exp=ff", name, cyc, SegmentDrivers);
            end
            if (SevenSegment !== ((cyc >= 3) ? 8'h99 : 8'hFF)) begin
                failures++;
                $display("FAIL %s_seg cyc=%0d got=%h exp=%h", name, cyc, SevenSegment,
                         (cyc >= 3) ? 8'h99 : 8'hFF);
            end
        end
    endtask

    task automatic test_reset();
        RESET_N = 1'b0;
        repeat (3) @(negedge clk);
        checks += 3;
        if (SegmentDrivers !== 8'hFF) begin failures++; $display("FAIL reset_drv got=%h exp=ff", SegmentDrivers); end
        if (SevenSegment !== 8'hFF) begin failures++; $display("FAIL reset_seg got=%h exp=ff", SevenSegment); end
        if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_frame_done got=%b exp=0", frame_done); end
        RESET_N = 1'b1;
        // Latched duty is 0 after reset: digit 0 data appears after 3 edges but stays dark.
        check_restart("reset_release");
        $display("txn reset: outputs idle, digit 0 data after 3 edges");
    endtask

    task automatic test_scan();
        pwm_in = 8'd255;
        wait_duty();
        run_slots("scan", 80, 255, 1'b0, 8'h99, 8'hB0, 8'hA4, 8'hF9);
    endtask

    task automatic test_pwm();
        pwm_in = 8'd0;
        wait_duty();
        run_slots("pwm0", 256, 0, 1'b0, 8'h99, 8'hB0, 8'hA4, 8'hF9);
        pwm_in = 8'd128;
        wait_duty();
        run_slots("pwm128", 256, 128, 1'b0, 8'h99, 8'hB0, 8'hA4, 8'hF9);
    endtask

    task automatic test_lzb();
        hours2 = 4'd0;
        lzb_en = 1'b1;
        pwm_in = 8'd255;
        wait_duty();
        run_slots("lzb_on", 80, 255, 1'b1, 8'h99, 8'hB0, 8'hA4, 8'hFF);
        lzb_en = 1'b0;
        repeat (40) @(negedge clk);
        run_slots("lzb_off", 80, 255, 1'b0, 8'h99, 8'hB0, 8'hA4, 8'hC0);
    endtask

    task automatic test_decode_colon();
        hours2   = 4'd1;
        mins1    = 4'd12;
        colon_in = 1'b1;
        repeat (40) @(negedge clk);
        run_slots("code12_colon", 80, 255, 1'b0, 8'hFF, 8'hB0, 8'h24, 8'hF9);
        mins1    = 4'd4;
        colon_in = 1'b0;
    endtask

    task automatic test_midslot();
        int n, c0, m;
        logic [7:0] es;
        mins2 = 4'd5;
        repeat (40) @(negedge clk);
        n = 0;
        while (!(cyc % 10 == 5 && (cyc / 10) % 4 == 1) && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 100) begin
            failures++;
            $display("FAIL midslot_sync_timeout cyc=%0d", cyc);
        end
        c0 = cyc;
        mins2 = 4'd3;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            m = cyc - 1;
            if ((m / 10) % 4 == 1 && m % 10 >= 2) begin
                es = (m <= c0 + 4) ? 8'h92 : 8'hB0;
                checks++;
                if (SevenSegment !== es) begin
                    failures++;
                    $display("FAIL midslot_seg cyc=%0d got=%h exp=%h", cyc, SevenSegment, es);
                end
            end
        end
        $display("txn midslot: mins2 5->3 at slot cycle 5 of digit 1");
    endtask

    task automatic test_async_reset();
        int n;
        n = 0;
        while (SegmentDrivers === 8'hFF && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 100) begin
            failures++;
            $display("FAIL async_reset_wait_on cyc=%0d", cyc);
        end
        #1 RESET_N = 1'b0;
        #1;
        checks += 3;
        if (SegmentDrivers !== 8'hFF) begin failures++; $display("FAIL async_reset_drv got=%h exp=ff", SegmentDrivers); end
        if (SevenSegment !== 8'hFF) begin failures++; $display("FAIL async_reset_seg got=%h exp=ff", SevenSegment); end
        if (frame_done !== 1'b0) begin failures++; $display("FAIL async_reset_frame_done got=%b exp=0", frame_done); end
        repeat (2) @(negedge clk);
        RESET_N = 1'b1;
        check_restart("async_release");
        $display("txn async_reset: immediate idle, restart at digit 0");
    endtask

    initial begin
        RESET_N  = 1'b0;
        hours2   = 4'd1;
        hours1   = 4'd2;
        mins2    = 4'd3;
        mins1    = 4'd4;
        pwm_in   = 8'd255;
        colon_in = 1'b0;
        lzb_en   = 1'b0;
        test_reset();
        test_scan();
        test_pwm();
        test_lzb();
        test_decode_colon();
        test_midslot();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
